// File: rtl/lock_on_reset.sv
// lock_on_reset: lockable data register.
//   The stored value can only be written on clock edges where `unlock` is
//   high. Reset forces it back to RESET_VALUE and leaves it locked.
//
// Ports:
//   clk     system clock, all updates on rising edge
//   reset   synchronous, active-high; beats unlock
//   unlock  level write-enable, sampled at each rising edge
//   d       [WIDTH-1:0] data stored while unlocked
//   locked  [WIDTH-1:0] registered protected value (no comb path from inputs)

// Per-bit storage cell. The top instantiates one per bit so each bit picks up
// its own reset value.
module lock_on_reset_bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic unlock,
  input  logic d,
  output logic q
);

  // Nothing here remembers an earlier unlock: every edge re-decides from the
  // live inputs. A low (or unknown) unlock drops into the hold path, so an
  // unknown value on d cannot reach q while the cell is locked.
  always_ff @(posedge clk) begin
    if (reset)       q <= RST_VAL;
    else if (unlock) q <= d;
  end

endmodule

module lock_on_reset #(
  parameter int                WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             unlock,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] locked
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    lock_on_reset_bit #(
      .RST_VAL (RESET_VALUE[i])
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .unlock (unlock),
      .d      (d[i]),
      .q      (locked[i])
    );
  end

endmodule

// File: tb/tb_lock_on_reset.sv
// Scoreboard bench for lock_on_reset (WIDTH=4, RESET_VALUE=0).
// The driver applies one directed vector per cycle on the falling edge and
// pushes the hand-computed value expected after the next rising edge; the
// monitor pops and compares shortly after each rising edge.
module tb_lock_on_reset;

  localparam int W = 4;

  typedef struct {
    logic         rst;
    logic         unl;
    logic [W-1:0] d;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         unlock = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] locked;

  int checks = 0;
  int errors = 0;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  bit           done = 1'b0;

  lock_on_reset #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .unlock (unlock),
    .d      (d),
    .locked (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: locked=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic u, input logic [W-1:0] dv,
                     input logic [W-1:0] e, input string n);
    vec_t v;
    v.rst = r; v.unl = u; v.d = dv; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  // Monitor: the register presents a new value every edge, so one entry is
  // consumed per rising edge once the driver has started.
  initial begin
    logic [W-1:0] e;
    string        n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, locked, e);
      end
    end
  end

  // Driver
  initial begin
    logic [W-1:0] last_exp;
    logic [W-1:0] xv;
    xv = 'x;
    //   rst unl d      expected name
    add(1, 0, 4'hF, 4'h0, "reset_clears");
    add(0, 0, 4'hF, 4'h0, "release_locked");
    add(0, 1, 4'hA, 4'hA, "unlocked_write_A");
    add(0, 1, 4'h0, 4'h0, "unlocked_write_0");
    add(0, 0, 4'hF, 4'h0, "hold0_cycle1");
    add(0, 0, 4'hF, 4'h0, "hold0_cycle2");
    add(0, 1, 4'h5, 4'h5, "unlock_rise_with_d");
    add(0, 1, 4'hC, 4'hC, "unlocked_write_C");
    add(0, 0, 4'h0, 4'hC, "unlock_fall_no_write");
    add(0, 0, 4'h3, 4'hC, "holdC_cycle2");
    add(0, 0, xv,   4'hC, "x_d_while_locked");
    add(0, 1, 4'hF, 4'hF, "write_F");
    add(1, 1, 4'hF, 4'h0, "reset_beats_unlock");
    add(0, 0, 4'hF, 4'h0, "post_reset_locked1");
    add(0, 0, 4'hF, 4'h0, "post_reset_locked2");
    add(0, 1, 4'h9, 4'h9, "post_reset_unlock");
    add(1, 0, 4'h0, 4'h0, "reset_again");
    add(0, 1, 4'hF, 4'hF, "one_edge_pulse");
    add(0, 0, 4'h0, 4'hF, "pulse_relocks");
    add(0, 0, 4'h1, 4'hF, "pulse_holds");
    add(1, 0, xv,   4'h0, "reset_with_x_d");
    add(0, 0, xv,   4'h0, "x_d_after_reset");

    last_exp = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset  = vecs[i].rst;
      unlock = vecs[i].unl;
      d      = vecs[i].d;
      exp_q.push_back(vecs[i].exp);
      name_q.push_back(vecs[i].name);
      // Output must not follow input changes between edges.
      if (i > 0) begin
        #1;
        check("no_comb_path", locked, last_exp);
      end
      last_exp = vecs[i].exp;
    end
    @(negedge clk);
    reset = 1'b0; unlock = 1'b0; d = '0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
    end
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout: done=0 expected=1");
      $fatal(1, "timeout");
    end
  end

endmodule
